// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller with a req/ack line memory port.
// Optional hit/miss statistics counters are enabled by defining DCACHE_STATS_EN.
module dcache_ctrl #(
    parameter int unsigned NUM_LINES = 32,
    parameter int unsigned LINE_BITS = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 MemRd_i,
    input  logic                 MemWr_i,
    input  logic [31:0]          addr_i,
    input  logic [31:0]          wdata_i,
    output logic [31:0]          rdata_o,
    output logic                 stall_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_wdata_o,
    input  logic [LINE_BITS-1:0] mem_rdata_i,
    input  logic                 mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]          hit_cnt_o,
    output logic [31:0]          miss_cnt_o
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_LINES);
    localparam int unsigned TAG_W = 32 - 5 - IDX_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WB,
        S_ALLOC,
        S_FILL
    } state_t;

    state_t state, state_n;

    logic [NUM_LINES-1:0] valid;
    logic [NUM_LINES-1:0] dirty;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [LINE_BITS-1:0] data_mem [NUM_LINES];
    logic [LINE_BITS-1:0] fill_buf;
    logic [LINE_BITS-1:0] cur_line;

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [2:0]       req_off;
    logic             req;
    logic             hit;
    logic             unused_addr_lsb;

    assign req_tag         = addr_i[31 -: TAG_W];
    assign req_idx         = addr_i[5 +: IDX_W];
    assign req_off         = addr_i[4:2];
    assign unused_addr_lsb = ^addr_i[1:0];

    assign req      = MemRd_i | MemWr_i;
    assign cur_line = data_mem[req_idx];
    assign hit      = req && valid[req_idx] && (tag_mem[req_idx] == req_tag) && (state == S_IDLE);

    // A simultaneous read and write is treated as a store, so no load data is returned.
    assign rdata_o = (hit && !MemWr_i) ? cur_line[{req_off, 5'b00000} +: 32] : '0;
    assign stall_o = (req && !hit) || (state != S_IDLE);

    always_comb begin
        state_n      = state;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        unique case (state)
            S_IDLE: begin
                if (req && !hit)
                    state_n = (valid[req_idx] && dirty[req_idx]) ? S_WB : S_ALLOC;
            end
            S_WB: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {tag_mem[req_idx], req_idx, 5'b00000};
                mem_wdata_o  = cur_line;
                if (mem_ack_i)
                    state_n = S_ALLOC;
            end
            S_ALLOC: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {req_tag, req_idx, 5'b00000};
                if (mem_ack_i)
                    state_n = S_FILL;
            end
            S_FILL: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= S_IDLE;
            valid <= '0;
            dirty <= '0;
        end else begin
            state <= state_n;
            if (state == S_FILL) begin
                valid[req_idx] <= 1'b1;
                dirty[req_idx] <= 1'b0;
            end else if (hit && MemWr_i) begin
                dirty[req_idx] <= 1'b1;
            end
        end
    end

    // Tag/data arrays carry no reset; a reset forces IDLE and clears valid, so nothing lands here.
    always_ff @(posedge clk_i) begin
        if (state == S_ALLOC && mem_ack_i)
            fill_buf <= mem_rdata_i;
        if (state == S_FILL) begin
            tag_mem[req_idx]  <= req_tag;
            data_mem[req_idx] <= fill_buf;
        end else if (hit && MemWr_i) begin
            data_mem[req_idx][{req_off, 5'b00000} +: 32] <= wdata_i;
        end
    end

`ifdef DCACHE_STATS_EN
    logic replay;

    // The first IDLE cycle after FILL is the replay of the missed access, not a fresh hit.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            replay     <= 1'b0;
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            replay <= (state == S_FILL);
            if (hit && !replay && hit_cnt_o != '1)
                hit_cnt_o <= hit_cnt_o + 32'd1;
            if (state == S_IDLE && state_n != S_IDLE && miss_cnt_o != '1)
                miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: table-driven accesses against a flat reference memory,
// a latency-modelling line memory, and hand-written reset sequences.
module tb_dcache_ctrl;

    localparam int LAT = 10;

    logic         clk_i;
    logic         rst_i;
    logic         MemRd_i;
    logic         MemWr_i;
    logic [31:0]  addr_i;
    logic [31:0]  wdata_i;
    logic [31:0]  rdata_o;
    logic         stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_wdata_o;
    logic [255:0] mem_rdata_i;
    logic         mem_ack_i;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_cnt_o;
    logic [31:0]  miss_cnt_o;
`endif

    dcache_ctrl #(.NUM_LINES(32), .LINE_BITS(256)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .MemRd_i      (MemRd_i),
        .MemWr_i      (MemWr_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .rdata_o      (rdata_o),
        .stall_o      (stall_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ack_i    (mem_ack_i)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt_o    (hit_cnt_o),
        .miss_cnt_o   (miss_cnt_o)
`endif
    );

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          miss;
        bit          wb;
        logic [31:0] wb_addr;
        logic [31:0] alloc_addr;
    } txn_t;

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
    } op_t;

    int           total = 0;
    int           bad   = 0;
    op_t          ops[$];
    logic [31:0]  sb_q[$];
    logic [31:0]  ref_words [logic [31:0]];
    logic [31:0]  mem_words [logic [31:0]];
    txn_t         tbl [9];

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    function automatic logic [31:0] default_word(input logic [31:0] a);
        logic [31:0] w;
        w = a & ~32'h3;
        if (w == 32'h40)
            return 32'h1234_5678;
        return (w ^ 32'h5A5A_0000) + 32'h0001_0001;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        logic [31:0] w;
        w = a & ~32'h3;
        return ref_words.exists(w) ? ref_words[w] : default_word(w);
    endfunction

    function automatic logic [255:0] ref_line(input logic [31:0] blk);
        logic [255:0] l;
        for (int w = 0; w < 8; w++)
            l[w*32 +: 32] = ref_rd(blk + 32'(w * 4));
        return l;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return mem_words.exists(a) ? mem_words[a] : default_word(a);
    endfunction

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    // Line memory: acks LAT cycles after a request appears, logging every transfer.
    initial begin
        int cnt;
        op_t op;
        cnt = 0;
        mem_ack_i = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(posedge clk_i);
            #2;
            mem_ack_i = 1'b0;
            if (!rst_i || !mem_enable_o) begin
                cnt = 0;
            end else begin
                cnt++;
                if (cnt == LAT) begin
                    cnt = 0;
                    op.wr = mem_write_o;
                    op.addr = mem_addr_o;
                    op.wdata = mem_wdata_o;
                    ops.push_back(op);
                    if (mem_write_o) begin
                        for (int w = 0; w < 8; w++)
                            mem_words[mem_addr_o + 32'(w * 4)] = mem_wdata_o[w*32 +: 32];
                    end else begin
                        for (int w = 0; w < 8; w++)
                            mem_rdata_i[w*32 +: 32] = mem_word(mem_addr_o + 32'(w * 4));
                    end
                    mem_ack_i = 1'b1;
                end
            end
        end
    end

    task automatic run_txn(input txn_t t);
        int           stalls;
        int           exp_stalls;
        int           exp_ops;
        bit           rd_bad;
        logic [31:0]  exp;
        logic [255:0] exp_line;
        exp_line = t.wb ? ref_line(t.wb_addr) : '0;
        ops.delete();
        @(posedge clk_i);
        #1;
        MemRd_i = t.rd;
        MemWr_i = t.wr;
        addr_i  = t.addr;
        wdata_i = t.wdata;
        if (t.wr)
            ref_words[t.addr & ~32'h3] = t.wdata;
        else
            sb_q.push_back(ref_rd(t.addr));
        stalls = 0;
        rd_bad = 0;
        @(negedge clk_i);
        while (stall_o && stalls < 500) begin
            if (rdata_o !== 32'h0)
                rd_bad = 1;
            stalls++;
            @(negedge clk_i);
        end
        exp_stalls = !t.miss ? 0 : (t.wb ? 2 * LAT + 2 : LAT + 2);
        exp_ops    = !t.miss ? 0 : (t.wb ? 2 : 1);
        chk("stall_cycles", stalls, exp_stalls);
        chk("rdata_zero_while_stalled", rd_bad, 0);
        if (!t.wr) begin
            exp = sb_q.pop_front();
            chk("load_data", rdata_o, exp);
        end else begin
            chk("store_rdata_zero", rdata_o, 0);
        end
        chk("mem_op_count", ops.size(), exp_ops);
        if (t.wb && ops.size() >= 1) begin
            chk("wb_is_write", ops[0].wr, 1);
            chk("wb_addr", ops[0].addr, t.wb_addr);
            chk("wb_line", ops[0].wdata, exp_line);
        end
        if (t.miss && ops.size() == exp_ops) begin
            chk("alloc_is_read", ops[exp_ops-1].wr, 0);
            chk("alloc_addr", ops[exp_ops-1].addr, t.alloc_addr);
        end
        @(posedge clk_i);
        #1;
        MemRd_i = 1'b0;
        MemWr_i = 1'b0;
    endtask

    initial begin
        txn_t post;
        int   n;
        //          rd    wr    addr          wdata         miss  wb    wb_addr     alloc_addr
        tbl[0] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,        1'b1, 1'b0, 32'h0,      32'h40};
        tbl[1] = '{1'b0, 1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0,     32'h0};
        tbl[2] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,        1'b0, 1'b0, 32'h0,      32'h0};
        tbl[3] = '{1'b1, 1'b0, 32'h0000_0440, 32'h0,        1'b1, 1'b1, 32'h40,     32'h440};
        tbl[4] = '{1'b1, 1'b0, 32'h0000_0840, 32'h0,        1'b1, 1'b0, 32'h0,      32'h840};
        tbl[5] = '{1'b1, 1'b1, 32'h0000_0848, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0,     32'h0};
        tbl[6] = '{1'b1, 1'b0, 32'h0000_0848, 32'h0,        1'b0, 1'b0, 32'h0,      32'h0};
        tbl[7] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,        1'b1, 1'b1, 32'h840,    32'h40};
        tbl[8] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,        1'b0, 1'b0, 32'h0,      32'h0};

        rst_i   = 1'b0;
        MemRd_i = 1'b0;
        MemWr_i = 1'b0;
        addr_i  = '0;
        wdata_i = '0;
        repeat (3) @(negedge clk_i);
        chk("rst_stall", stall_o, 0);
        chk("rst_mem_enable", mem_enable_o, 0);
        chk("rst_mem_write", mem_write_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_wdata", mem_wdata_o, 0);
        chk("rst_rdata", rdata_o, 0);
`ifdef DCACHE_STATS_EN
        chk("rst_hit_cnt", hit_cnt_o, 0);
        chk("rst_miss_cnt", miss_cnt_o, 0);
`endif
        rst_i = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_txn(tbl[i]);
`ifdef DCACHE_STATS_EN
            if (i == 4) begin
                chk("stats_hit_cnt", hit_cnt_o, 2);
                chk("stats_miss_cnt", miss_cnt_o, 3);
            end
`endif
        end

        // Reset mid-ALLOC: refill of 0x840 (victim 0x40 is clean) is aborted.
        ops.delete();
        @(posedge clk_i);
        #1;
        MemRd_i = 1'b1;
        addr_i  = 32'h0000_0840;
        n = 0;
        @(negedge clk_i);
        while (!mem_enable_o && n < 50) begin
            n++;
            @(negedge clk_i);
        end
        chk("alloc_before_reset", {mem_enable_o, mem_write_o, mem_addr_o}, {1'b1, 1'b0, 32'h840});
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("reset_drops_enable", mem_enable_o, 0);
        chk("reset_clears_addr", mem_addr_o, 0);
        MemRd_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        chk("aborted_alloc_no_ack", ops.size(), 0);
`ifdef DCACHE_STATS_EN
        chk("reset_hit_cnt", hit_cnt_o, 0);
`endif

        // The line at 0x40 was valid before reset; it must miss again.
        post = '{1'b1, 1'b0, 32'h0000_0044, 32'h0, 1'b1, 1'b0, 32'h0, 32'h40};
        run_txn(post);

        repeat (2) @(negedge clk_i);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache controller between the pipeline MEM stage and a slow block-oriented data memory.
- Serves loads and stores from the MEM stage and raises a stall on a miss.
- Refills or evicts whole 256-bit lines over a req/ack memory interface.
- Stall is consumed by the pipeline to freeze PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

Parameters:
NUM_LINES, 32, number of cache lines; power of 2, minimum 2
LINE_BITS, 256, line width in bits; fixed at 8 words of 32 bits

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous, active-low reset
MemRd_i  input  1  load request from MEM stage
MemWr_i  input  1  store request from MEM stage
addr_i  input  32  byte address; [1:0] ignored, word aligned
wdata_i  input  32  store data
rdata_o  output  32  load data
stall_o  output  1  pipeline stall
mem_enable_o  output  1  memory request
mem_write_o  output  1  1 = write-back, 0 = refill read
mem_addr_o  output  32  block-aligned address; [4:0] = 0
mem_wdata_o  output  256  evicted line
mem_rdata_i  input  256  refill line
mem_ack_i  input  1  one-cycle completion pulse

Behaviour:
- Address split: offset [4:2] selects the word; index is the next log2(NUM_LINES) bits; tag is the remaining upper bits (22 bits at default).
- Storage per line: valid, dirty, tag, 256-bit data.
- Request = MemRd_i | MemWr_i. If both are high, treat the request as a store.
- Hit = request & valid & tag match & state IDLE.
- Read hit: rdata_o carries the word combinationally in the same cycle. stall_o = 0.
- Otherwise rdata_o = 0.
- Write hit: the word is written at the clock edge and dirty is set. stall_o = 0.
- stall_o = request & !hit (combinational). It stays high in every non-IDLE state.
- FSM states: IDLE, WB, ALLOC, FILL.
- IDLE: on a miss, go to WB if the victim is valid & dirty, else go to ALLOC.
- WB: mem_enable_o = 1, mem_write_o = 1, mem_addr_o = {victim tag, index, 5'b0}, mem_wdata_o = victim line. Held stable until mem_ack_i, then go to ALLOC.
- ALLOC: mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {request tag, index, 5'b0}. On mem_ack_i, capture mem_rdata_i, then go to FILL.
- FILL: write the line with valid = 1, dirty = 0, tag = request tag, then go to IDLE. The original access replays in IDLE as a hit, which also merges a pending store and sets dirty.
- Minimum miss latency: clean miss is 2 cycles plus memory latency; dirty miss adds WB plus its memory latency.
- mem_ack_i is ignored in IDLE and FILL.
- Memory latency is unbounded; no timeout.
- The request must stay stable while stall_o is high; the pipeline guarantees this.
- mem_enable_o, mem_write_o, mem_addr_o and mem_wdata_o are 0 in IDLE and FILL.
- Reset (asynchronous, active low): all valid and dirty bits = 0, state = IDLE, all outputs = 0. Tag and data contents are don't-care.
- Reset mid-miss aborts immediately: mem_enable_o drops asynchronously and no line is written.
- Index wrap: none; each index is an independent line.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined: adds output ports hit_cnt_o[31:0] and miss_cnt_o[31:0].
  - hit_cnt_o increments once per IDLE hit, excluding replays after FILL.
  - miss_cnt_o increments once per IDLE-to-WB or IDLE-to-ALLOC transition.
  - Both counters saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: the ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
- Cold load: after reset, MemRd_i with addr 0x0000_0040.
  - stall_o = 1, ALLOC issued at mem_addr_o = 0x40.
  - Memory acks after 10 cycles with word 0 = 0x1234_5678.
  - Load completes with rdata_o = 0x1234_5678; stall_o low on the replay cycle.
- Store hit: store 0xDEAD_BEEF to 0x44 → no stall. A later load from 0x44 returns 0xDEAD_BEEF with zero stall cycles.
- Dirty eviction: at the default 32 lines, load 0x0000_0440 (same index, different tag).
  - WB issues first at mem_addr_o = 0x40 with mem_wdata_o word 1 = 0xDEAD_BEEF.
  - ALLOC follows at 0x440.
- Clean conflict: load 0x840 after the line above was refilled clean → ALLOC only; mem_write_o never asserted.
- Reset mid-ALLOC: assert rst_i low while mem_enable_o = 1.
  - mem_enable_o = 0 immediately.
  - After release, a load from 0x40 misses again (valid cleared).
- Stats (DCACHE_STATS_EN): run the sequence above without the reset step → hit_cnt_o = 2, miss_cnt_o = 3.
